// File: rtl/spi_flash_boot_loader.sv
// spi_flash_boot_loader: copies a boot image from SPI NOR flash (READ 0x03) into BRAM while holding the CPU in reset.
// Ports: clk/reset (async, active-high); memAddress/memWriteData/byteMask/memWrite drive the shared bus;
// busOwn selects this block on the bus; cpuReset holds the CPU; done is sticky after the copy;
// spiSck/spiCs_n/spiMosi/spiMiso form a mode-0 SPI master port.
module spi_flash_boot_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h10_0000,
  parameter logic [31:0] BRAM_BASE  = 32'h0000_0000,
  parameter int          WORD_COUNT = 128,
  parameter int          CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite,
  output logic        busOwn,
  output logic        cpuReset,
  output logic        done,
  output logic        spiSck,
  output logic        spiCs_n,
  output logic        spiMosi,
  input  logic        spiMiso
);
  localparam int IW = $clog2(WORD_COUNT) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, FINISH, DONE} state_t;
  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [5:0]    bit_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   tx_q, rx_q, addr_q, wdata_q;
  logic          we_q, sck_q, cs_n_q, own_q;
  logic          half_end, last_bit;
  assign half_end = div_q == DW'(CLK_DIV - 1);
  assign last_bit = bit_q == (state_q == CMD ? 6'd7 : state_q == ADDR ? 6'd23 : 6'd31);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      own_q   <= 1'b1;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= CS_SETUP;
          cs_n_q  <= 1'b0;
          tx_q    <= {8'h03, FLASH_BASE};
          div_q   <= '0;
        end
        CS_SETUP: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) state_q <= CMD;
        end
        CMD, ADDR, DATA: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) sck_q <= ~sck_q;
          if (half_end && !sck_q && state_q == DATA) rx_q <= {rx_q[30:0], spiMiso};
          // end of a high half: advance to the next bit; tx shifts in zeros so MOSI idles low after the address
          if (half_end && sck_q) begin
            bit_q <= last_bit ? '0 : bit_q + 1'b1;
            tx_q  <= tx_q << 1;
            if (last_bit) begin
              if (state_q == CMD) state_q <= ADDR;
              else if (state_q == ADDR) state_q <= DATA;
              else begin
                state_q <= WRITE;
                we_q    <= 1'b1;
                addr_q  <= BRAM_BASE + (32'(idx_q) << 2);
                // first received byte becomes the least significant byte
                wdata_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              end
            end
          end
        end
        WRITE: begin
          if (idx_q == IW'(WORD_COUNT - 1)) begin
            state_q <= FINISH;
            cs_n_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= DATA;
          end
        end
        FINISH: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) begin
            state_q <= DONE;
            own_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  assign memAddress   = addr_q;
  assign memWriteData = wdata_q;
  assign byteMask     = {4{we_q}};
  assign memWrite     = we_q;
  assign busOwn       = own_q;
  assign cpuReset     = own_q;
  assign done         = ~own_q;
  assign spiSck       = sck_q;
  assign spiCs_n      = cs_n_q;
  assign spiMosi      = tx_q[31];
endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// tb_spi_flash_boot_loader: directed scoreboard bench for two loader configurations with behavioural SPI flash models.
module tb_spi_flash_boot_loader;
  logic        clk = 1'b0;
  logic        r0 = 1'b1, r1 = 1'b1;
  logic [31:0] a0, d0, a1, d1;
  logic [3:0]  bm0, bm1;
  logic        we0, own0, cr0, done0, sck0, cs0, mosi0;
  logic        we1, own1, cr1, done1, sck1, cs1, mosi1;
  logic        m0 = 1'b0, m1 = 1'b0;
  int          fr0 = 0, fr1 = 0;
  logic [31:0] fc0 = '0, fc1 = '0;
  logic [7:0]  f1 [4] = '{8'h13, 8'h05, 8'h50, 8'h00};
  logic [63:0] q[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_flash_boot_loader #(.WORD_COUNT(4), .CLK_DIV(2)) u0 (
    .clk(clk), .reset(r0), .memAddress(a0), .memWriteData(d0), .byteMask(bm0), .memWrite(we0),
    .busOwn(own0), .cpuReset(cr0), .done(done0), .spiSck(sck0), .spiCs_n(cs0), .spiMosi(mosi0), .spiMiso(m0));

  spi_flash_boot_loader #(.WORD_COUNT(1), .CLK_DIV(1)) u1 (
    .clk(clk), .reset(r1), .memAddress(a1), .memWriteData(d1), .byteMask(bm1), .memWrite(we1),
    .busOwn(own1), .cpuReset(cr1), .done(done1), .spiSck(sck1), .spiCs_n(cs1), .spiMosi(mosi1), .spiMiso(m1));

  function automatic logic fbit(input int b, input logic [7:0] v);
    return v[7 - b % 8];
  endfunction

  // flash 0: image bytes 00,01,02,... ; flash 1: 13,05,50,00 then zeros
  always @(posedge sck0 or posedge cs0)
    if (cs0) begin
      fr0 <= 0;
      fc0 <= '0;
    end else begin
      if (fr0 < 32) fc0 <= {fc0[30:0], mosi0};
      fr0 <= fr0 + 1;
    end
  always @(negedge sck0) if (!cs0 && fr0 >= 32) m0 <= fbit(fr0 - 32, 8'((fr0 - 32) / 8));

  always @(posedge sck1 or posedge cs1)
    if (cs1) begin
      fr1 <= 0;
      fc1 <= '0;
    end else begin
      if (fr1 < 32) fc1 <= {fc1[30:0], mosi1};
      fr1 <= fr1 + 1;
    end
  always @(negedge sck1) if (!cs1 && fr1 >= 32) m1 <= fbit(fr1 - 32, (fr1 - 32) / 8 < 4 ? f1[(fr1 - 32) / 8] : 8'h00);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic push_word(input int i);
    q.push_back({32'(4 * i), 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
  endtask

  task automatic run0(input int max_cyc, input int stop_rise, input int stop_wr);
    int n, w, run, hb, lb;
    logic ps, pw, cmd_ok;
    logic [63:0] e;
    n = 0; w = 0; run = 0; hb = 0; lb = 0; ps = sck0; pw = 1'b0; cmd_ok = 1'b0;
    while (!done0 && n < max_cyc && (stop_rise == 0 || fr0 < stop_rise) && (stop_wr == 0 || w < stop_wr)) begin
      @(negedge clk);
      n++;
      if (sck0 != ps) begin
        if (ps && run != 2) hb++;
        if (!ps && fr0 >= 2 && fr0 <= 32 && run != 2) lb++;
        run = 1;
      end else run++;
      ps = sck0;
      if (!cmd_ok && fr0 >= 32) begin
        cmd_ok = 1'b1;
        chk("cmd_addr_stream", 64'(fc0), 64'h0310_0000);
      end
      if (we0) begin
        w++;
        e = '1;
        if (q.size() != 0) e = q.pop_front();
        chk("write_addr_data", {a0, d0}, e);
        chk("write_mask", 64'(bm0), 64'hF);
        chk("write_sck_low", 64'(sck0), 64'h0);
        chk("write_one_clk", 64'(pw), 64'h0);
      end
      pw = we0;
    end
    chk("run_bound", 64'(n < max_cyc), 64'h1);
    chk("sck_high_halves", 64'(hb), 64'h0);
    chk("sck_low_halves", 64'(lb), 64'h0);
  endtask

  initial begin
    int n, rc, hb, wc;
    logic ps, any;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {we0, bm0, cs0, sck0, mosi0, cr0, own0, done0}, {1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("rst_bus", {a0, d0}, 64'h0);
    chk("rst_ctrl_b", {we1, cs1, sck1, cr1, own1, done1}, 6'b010110);
    for (int i = 0; i < 4; i++) push_word(i);
    r0 = 1'b0;
    n = 0;
    while (cs0 && n < 2) begin
      @(negedge clk);
      n++;
    end
    chk("cs_fall", 64'(cs0), 64'h0);
    any = sck0;
    repeat (2) begin
      @(negedge clk);
      any = any | sck0;
    end
    chk("sck_quiet_after_cs", 64'(any), 64'h0);
    run0(3000, 0, 0);
    chk("all_writes", 64'(q.size()), 64'h0);
    chk("done_state", {done0, cr0, own0, cs0, sck0, mosi0}, 6'b100100);
    wc = 0;
    repeat (1000) begin
      @(negedge clk);
      if (we0) wc++;
    end
    chk("idle_no_write", 64'(wc), 64'h0);
    chk("done_sticky", 64'(done0), 64'h1);

    r0 = 1'b1;
    repeat (3) @(negedge clk);
    r0 = 1'b0;
    push_word(0);
    push_word(1);
    run0(2000, 32 + 64 + 10, 0);
    chk("mid_two_writes", 64'(q.size()), 64'h0);
    r0 = 1'b1;
    #1;
    chk("midrst_async", {cs0, we0, sck0, own0, cr0}, 5'b10011);
    chk("midrst_bus", {a0, d0}, 64'h0);
    repeat (3) @(negedge clk);
    r0 = 1'b0;
    push_word(0);
    run0(1000, 0, 1);
    chk("restart_first_write", 64'(q.size()), 64'h0);

    r1 = 1'b0;
    n = 0; rc = 0; hb = 0; wc = 0; ps = sck1;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
      if (sck1 && !ps) rc++;
      if (sck1 && ps) hb++;
      if (we1) begin
        wc++;
        chk("c_write", {a1, d1}, {32'h0, 32'h0050_0513});
        chk("c_mask", 64'(bm1), 64'hF);
        chk("c_sck_low", 64'(sck1), 64'h0);
      end
      ps = sck1;
    end
    chk("c_latency", 64'(n <= 140), 64'h1);
    chk("c_rises", 64'(rc), 64'd64);
    chk("c_writes", 64'(wc), 64'h1);
    chk("c_high_half", 64'(hb), 64'h0);
    chk("c_done", {done1, cr1, own1, cs1}, 4'b1001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
